pipeline_hazard_ctrl: RTL and testbench

Control end of the pipeline registers. It generates the hold (stall) and clear (flush) controls that the PC, IF/ID and ID/EX pipeline registers consume.
- Detects load-use hazards and taken-branch flushes.
- Tracks a multi-cycle mult/div unit and stalls HI/LO readers until the result is ready.
- Keeps a saturating stall-cycle statistic.

---
 rtl/pipeline_pkg.sv | 19 +
 rtl/md_busy_counter.sv | 86 ++++++++
 rtl/pipeline_hazard_ctrl.sv | 75 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// pipeline_pkg : shared types and constants for the pipeline hazard control
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         MD_CNT_WIDTH = 8;

endpackage

`default_nettype wire

// File: rtl/md_busy_counter.sv
// ============================================================================
// md_busy_counter : tracks an in-flight mult/div and flags when HI/LO is usable
// Rev 1.0
// ============================================================================
`default_nettype none

module md_busy_counter
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_md_start,
  output logic o_md_busy,
  output logic o_md_done
);

  localparam logic [MD_CNT_WIDTH-1:0] c_reload = MD_CNT_WIDTH'(MD_LATENCY - 1);
  localparam logic [MD_CNT_WIDTH-1:0] c_one    = MD_CNT_WIDTH'(1);

  md_state_e                r_state;
  md_state_e                w_state_nxt;
  logic [MD_CNT_WIDTH-1:0]  r_count;
  logic [MD_CNT_WIDTH-1:0]  w_count_nxt;
  logic                     w_busy;
  logic                     w_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      RUN: begin
        if (i_md_start) begin
          w_state_nxt = MD_WAIT;
          w_count_nxt = c_reload;
        end
      end
      MD_WAIT: begin
        if (r_count != '0) begin
          // A start while busy is dropped; the running operation keeps counting.
          w_busy      = 1'b1;
          w_count_nxt = r_count - c_one;
        end else begin
          w_done = 1'b1;
          if (i_md_start) begin
            w_count_nxt = c_reload;
          end else begin
            w_state_nxt = RUN;
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_count_nxt = '0;
      end
    endcase
  end

  assign o_md_busy = w_busy & rst_n;
  assign o_md_done = w_done & rst_n;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && i_md_start) begin
      assert (!w_busy)
        else $warning("md_busy_counter: ex_md_start while busy, start ignored");
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush generation for PC, IF/ID and ID/EX regs
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4:0]            id_rs,
  input  logic [4:0]            id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_reads_hilo,
  input  logic                  id_branch_taken,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_write_reg,
  input  logic                  ex_md_start,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  md_busy,
  output logic                  md_done,
  output logic [STAT_WIDTH-1:0] stall_cycles
);

  localparam logic [STAT_WIDTH-1:0] c_stat_one = STAT_WIDTH'(1);

  logic                  w_md_busy;
  logic                  w_md_done;
  logic                  w_load_hazard;
  logic                  w_md_hazard;
  logic                  w_stall;
  logic [STAT_WIDTH-1:0] r_stall_cycles;

  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_counter (
    .clk        (clock),
    .rst_n      (reset_n),
    .i_md_start (ex_md_start),
    .o_md_busy  (w_md_busy),
    .o_md_done  (w_md_done)
  );

  assign w_load_hazard = ex_mem_read && (ex_write_reg != REG_ZERO) &&
                         ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
  assign w_md_hazard   = w_md_busy && id_reads_hilo;
  assign w_stall       = reset_n && (w_load_hazard || w_md_hazard);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + c_stat_one;
    end
  end

  // A stall holds the branch in ID, so it is re-evaluated rather than flushed now.
  assign stall_pc     = w_stall;
  assign stall_ifid   = w_stall;
  assign flush_idex   = w_stall;
  assign flush_ifid   = reset_n && id_branch_taken && !w_stall;
  assign md_busy      = w_md_busy;
  assign md_done      = w_md_done;
  assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed + random checks against a timeline model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs, id_rt, ex_write_reg;
  logic       id_uses_rt, id_reads_hilo, id_branch_taken, ex_mem_read, ex_md_start;

  wire [5:0]  ctl_a, ctl_b;
  wire [31:0] sc_a;
  wire [3:0]  sc_b;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .STAT_WIDTH(32)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo),
    .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .ex_md_start(ex_md_start),
    .stall_pc(ctl_a[5]), .stall_ifid(ctl_a[4]), .flush_ifid(ctl_a[3]),
    .flush_idex(ctl_a[2]), .md_busy(ctl_a[1]), .md_done(ctl_a[0]),
    .stall_cycles(sc_a)
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(1), .STAT_WIDTH(4)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rt(id_uses_rt), .id_reads_hilo(id_reads_hilo),
    .id_branch_taken(id_branch_taken), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .ex_md_start(ex_md_start),
    .stall_pc(ctl_b[5]), .stall_ifid(ctl_b[4]), .flush_ifid(ctl_b[3]),
    .flush_idex(ctl_b[2]), .md_busy(ctl_b[1]), .md_done(ctl_b[0]),
    .stall_cycles(sc_b)
  );

  // Model: each mult/div is a start cycle plus the cycle at which its result lands.
  int     lat[2]    = '{4, 1};
  longint satmax[2] = '{64'hFFFF_FFFF, 15};
  bit     m_active[2];
  longint m_done_at[2];
  longint m_cnt[2];
  longint cyc;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit load_hz();
    return ex_mem_read && (ex_write_reg != 5'd0) &&
           ((ex_write_reg == id_rs) || (id_uses_rt && (ex_write_reg == id_rt)));
  endfunction

  task automatic step();
    bit          busy, done, st;
    logic [63:0] got_cnt;
    @(negedge clock);
    #2;
    for (int i = 0; i < 2; i++) begin
      busy = m_active[i] && (cyc < m_done_at[i]);
      done = m_active[i] && (cyc == m_done_at[i]);
      st   = load_hz() || (busy && id_reads_hilo);
      if (!reset_n) begin
        busy = 1'b0; done = 1'b0; st = 1'b0;
      end
      got_cnt = (i == 0) ? 64'(sc_a) : 64'(sc_b);
      check($sformatf("ctl%0d@%0d", i, cyc), 64'((i == 0) ? ctl_a : ctl_b),
            64'({st, st, id_branch_taken && !st && reset_n, st, busy, done}));
      check($sformatf("cnt%0d@%0d", i, cyc), got_cnt, 64'(m_cnt[i]));
    end
    @(posedge clock);
    for (int i = 0; i < 2; i++) begin
      busy = m_active[i] && (cyc < m_done_at[i]);
      done = m_active[i] && (cyc == m_done_at[i]);
      st   = load_hz() || (busy && id_reads_hilo);
      if (!reset_n) begin
        m_active[i] = 1'b0;
        m_cnt[i]    = 0;
      end else begin
        if (ex_md_start && !busy) begin
          m_active[i]  = 1'b1;
          m_done_at[i] = cyc + lat[i];
        end else if (done) begin
          m_active[i] = 1'b0;
        end
        if (st && m_cnt[i] < satmax[i]) m_cnt[i]++;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic idle();
    reset_n = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_write_reg = 5'd0;
    id_uses_rt = 1'b0; id_reads_hilo = 1'b0; id_branch_taken = 1'b0;
    ex_mem_read = 1'b0; ex_md_start = 1'b0;
  endtask

  task automatic md_run(input int start_at_b2b, input int start_busy, input int rst_at);
    ex_md_start = 1'b1; id_reads_hilo = 1'b1; step();
    ex_md_start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      ex_md_start = (k == start_at_b2b) || (k == start_busy);
      reset_n     = (k != rst_at);
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n = 1'b0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 1'b0; m_done_at[i] = 0; m_cnt[i] = 0;
    end
    repeat (2) @(posedge clock);
    #1;
    step();
    idle();

    // load-use on rs, then a zero destination never hazards
    ex_mem_read = 1'b1; ex_write_reg = 5'd8; id_rs = 5'd8; step();
    ex_write_reg = 5'd0; id_rs = 5'd0; step();
    // rt gating
    ex_write_reg = 5'd9; id_rs = 5'd1; id_rt = 5'd9; id_uses_rt = 1'b0; step();
    id_uses_rt = 1'b1; step();
    idle();
    // branch alone, branch under a stall, branch re-presented
    id_branch_taken = 1'b1; step();
    ex_mem_read = 1'b1; ex_write_reg = 5'd3; id_rs = 5'd3; step();
    ex_mem_read = 1'b0; step();
    idle();

    md_run(0, 0, 0);   // plain 4-cycle operation
    md_run(4, 0, 0);   // back-to-back start on the done cycle
    md_run(0, 2, 0);   // start while busy is ignored
    md_run(0, 0, 2);   // reset mid-operation

    // saturation of the narrow counter
    ex_mem_read = 1'b1; ex_write_reg = 5'd7; id_rs = 5'd7;
    repeat (20) step();
    idle();

    for (int n = 0; n < 3000; n++) begin
      reset_n         = ($urandom_range(0, 63) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_write_reg    = 5'($urandom_range(0, 3));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_reads_hilo   = 1'($urandom_range(0, 1));
      id_branch_taken = ($urandom_range(0, 3) == 0);
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_md_start     = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, total=%0d", total);
    $fatal(1);
  end

endmodule

`default_nettype wire
